// File: rtl/mfcc_scheduler.sv
// mfcc_scheduler: sequences window/FFT/mel/cepstrum units per frame with done handshakes and timeout.
module mfcc_scheduler #(
  parameter int FRAME_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               trigger,
  input  logic               abort,
  input  logic [FRAME_W-1:0] frame_num,
  input  logic [3:0]         fft_stage_number,
  input  logic               win_done,
  input  logic               fft_done,
  input  logic               mel_done,
  input  logic               cep_done,
  output logic               win_start,
  output logic               fft_start,
  output logic               mel_start,
  output logic               cep_start,
  output logic [3:0]         fft_stage,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, WIN, WIN_W, FFT, FFT_W, MEL, MEL_W, CEP, CEP_W, NEXT, FIN} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic [FRAME_W-1:0] frame_n;
  logic [3:0] fft_n;
  logic unit_done, waiting;
  always_comb begin
    unit_done = state == WIN_W ? win_done :
                state == FFT_W ? fft_done :
                state == MEL_W ? mel_done :
                state == CEP_W ? cep_done : 1'b0;
    waiting = state inside {WIN_W, FFT_W, MEL_W, CEP_W};
  end
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= IDLE;
      wait_cnt <= '0;
      frame_n <= '0;
      fft_n <= '0;
      {win_start, fft_start, mel_start, cep_start} <= '0;
      fft_stage <= '0;
      frame_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      {win_start, fft_start, mel_start, cep_start} <= '0;
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (waiting && !unit_done) begin
        if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          err <= 1'b1;
        end else
          wait_cnt <= wait_cnt + 1'b1;
      end else
        case (state)
          IDLE: if (trigger) begin
            frame_n <= frame_num;
            fft_n <= fft_stage_number;
            err <= 1'b0;
            frame_idx <= '0;
            busy <= 1'b1;
            if (frame_num == '0) begin
              state <= FIN;
              done <= 1'b1;
            end else begin
              state <= WIN;
              win_start <= 1'b1;
            end
          end
          // each issue state is immediately followed by its wait state in the encoding
          WIN, FFT, MEL, CEP: begin
            state <= state_t'(state + 4'd1);
            wait_cnt <= '0;
          end
          WIN_W: if (fft_n == 4'd0) begin
            state <= MEL;
            mel_start <= 1'b1;
          end else begin
            state <= FFT;
            fft_start <= 1'b1;
            fft_stage <= 4'd0;
          end
          FFT_W: if ({1'b0, fft_stage} + 5'd1 < {1'b0, fft_n}) begin
            state <= FFT;
            fft_start <= 1'b1;
            fft_stage <= fft_stage + 4'd1;
          end else begin
            state <= MEL;
            mel_start <= 1'b1;
          end
          MEL_W: begin
            state <= CEP;
            cep_start <= 1'b1;
          end
          CEP_W: state <= NEXT;
          NEXT: if (frame_idx == frame_n - 1'b1) begin
            state <= FIN;
            done <= 1'b1;
          end else begin
            state <= WIN;
            win_start <= 1'b1;
            frame_idx <= frame_idx + 1'b1;
          end
          default: begin
            state <= IDLE;
            busy <= 1'b0;
          end
        endcase
    end
  end
endmodule
